// File: rtl/mx_page_mapper.sv
// Windowed page mapper for the Specialist MX RAM-disk: per-window page registers
// written via the page-select port, combinational SDRAM address and ROM flag.
module mx_page_mapper #(
    parameter int          PAGE_BITS  = 4,
    parameter int          NUM_WIN    = 4,
    parameter int          ROM_PAGE   = 1,
    parameter int          RD_BASE    = 2,
    parameter int          RD_PAGES   = 8,
    parameter logic [15:0] FIXED_BASE = 16'hFFC0,
    parameter int          ADDR_W     = 25
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          io_reset,
    input  logic                          mapper_en,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_dout,
    input  logic                          cpu_wr_n,
    input  logic                          page_sel,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          rom_active,
    output logic [NUM_WIN*PAGE_BITS-1:0]  win_pages
);

    localparam int WIN_BITS = $clog2(NUM_WIN);
    localparam int WB       = (WIN_BITS == 0) ? 1 : WIN_BITS;

    logic [PAGE_BITS-1:0] page     [NUM_WIN];
    logic [PAGE_BITS-1:0] page_nxt [NUM_WIN];
    logic                 old_wr;
    logic                 armed;
    logic                 accept;
    logic                 fixed_hit;
    logic [WB-1:0]        win_idx;
    logic [WB-1:0]        dout_win;
    logic [PAGE_BITS-1:0] rd_page;

    // Shifting by the full width yields 0, so NUM_WIN = 1 needs no special case.
    assign win_idx   = WB'(cpu_addr >> (16 - WIN_BITS));
    assign dout_win  = WB'(cpu_dout >> (8 - WIN_BITS));
    assign rd_page   = PAGE_BITS'(RD_BASE) + PAGE_BITS'(cpu_dout & 8'(RD_PAGES - 1));
    assign accept    = armed & old_wr & ~cpu_wr_n & page_sel & mapper_en;
    assign fixed_hit = (cpu_addr >= FIXED_BASE);

    always_comb begin
        page_nxt = page;
        if (io_reset) begin
            for (int unsigned w = 0; w < NUM_WIN; w++) page_nxt[w] = '0;
        end else if (accept) begin
            case (cpu_addr[1:0])
                2'b00: for (int unsigned w = 0; w < NUM_WIN; w++) page_nxt[w] = '0;
                2'b01: for (int unsigned w = 0; w < NUM_WIN; w++) page_nxt[w] = rd_page;
                2'b10: for (int unsigned w = 0; w < NUM_WIN; w++) page_nxt[w] = PAGE_BITS'(ROM_PAGE);
                default: begin
                    if (NUM_WIN == 1 && cpu_dout[7])
                        page_nxt[0] = PAGE_BITS'(ROM_PAGE);
                    else
                        page_nxt[dout_win] = rd_page;
                end
            endcase
        end else if (!mapper_en && cpu_addr[15]) begin
            for (int unsigned w = 0; w < NUM_WIN; w++) page_nxt[w] = '0;
        end
    end

    // armed holds off accepts for the first edge after reset release, so a write
    // strobe already low during reset needs a fresh high->low transition.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WIN; w++) page[w] <= PAGE_BITS'(ROM_PAGE);
            old_wr <= 1'b1;
            armed  <= 1'b0;
        end else begin
            page   <= page_nxt;
            old_wr <= cpu_wr_n;
            armed  <= 1'b1;
        end
    end

    always_comb begin
        win_pages = '0;
        for (int unsigned w = 0; w < NUM_WIN; w++)
            win_pages[w*PAGE_BITS +: PAGE_BITS] = page[w];
    end

    assign ram_addr   = fixed_hit ? ADDR_W'(cpu_addr) : ADDR_W'({page[win_idx], cpu_addr});
    assign rom_active = ~fixed_hit & (page[win_idx] == PAGE_BITS'(ROM_PAGE));

endmodule

// File: doc/mx_page_mapper.md
# mx_page_mapper

Parametrised memory page mapper for the Specialist MX RAM-disk model. It sits between the CPU address bus and the SDRAM controller and holds one page register per address window, written through the page-select I/O port. It drives the extended RAM address and a ROM-active flag. It supersedes the single global page register: the 64 KB CPU space is split into NUM_WIN independently mappable windows, and a fixed base region always maps to main RAM.

## Interface
Parameters:
- PAGE_BITS, 4: width of each page register (page = 64 KB bank number).
- NUM_WIN, 4: number of equal CPU windows; power of two, 1..8; WIN_BITS = log2(NUM_WIN).
- ROM_PAGE, 1: page loaded on reset and by port offset 2/3.
- RD_BASE, 2: first RAM-disk page.
- RD_PAGES, 8: RAM-disk page count; power of two; RD_BITS = log2(RD_PAGES); RD_BASE+RD_PAGES ≤ 2^PAGE_BITS.
- FIXED_BASE, 16'hFFC0: addresses ≥ FIXED_BASE always map to page 0.
- ADDR_W, 25: output address width; ≥ 16+PAGE_BITS.

Ports:
- clk_sys  in  1  system clock (48 MHz); all state on posedge.
- reset  in  1  asynchronous, active-high.
- io_reset  in  1  synchronous, active-high; forces all windows to page 0 (RKS load).
- mapper_en  in  1  MX-with-disk mode active (mx & mxd & ~mxm).
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU data out.
- cpu_wr_n  in  1  CPU write strobe, active-low.
- page_sel  in  1  page-port decode (FFFC–FFFF).
- ram_addr  out  ADDR_W  mapped SDRAM address.
- rom_active  out  1  window addressed by cpu_addr holds ROM_PAGE and address < FIXED_BASE.
- win_pages  out  NUM_WIN*PAGE_BITS  all page registers, window 0 in LSBs.

## Operation
- State: page[w] for w = 0..NUM_WIN-1, and old_wr (registered cpu_wr_n).
- Window index = cpu_addr[15:16-WIN_BITS]. When NUM_WIN = 1, the index is always 0.
- ram_addr (combinational):
  - cpu_addr ≥ FIXED_BASE → {0, cpu_addr}.
  - Otherwise → {page[win], cpu_addr}, zero-extended to ADDR_W.
- Write accept: old_wr=1 & cpu_wr_n=0 & page_sel=1 & mapper_en=1. Exactly one accept per CPU write cycle.
- On accept, decode by cpu_addr[1:0]:
  - 00: all windows ← 0.
  - 01: all windows ← RD_BASE + cpu_dout[RD_BITS-1:0]. Upper data bits are ignored, so the index wraps modulo RD_PAGES.
  - 10: all windows ← ROM_PAGE.
  - 11: only window cpu_dout[7:8-WIN_BITS] ← RD_BASE + cpu_dout[RD_BITS-1:0]. If cpu_dout[7] = 1 and NUM_WIN = 1, ROM_PAGE is loaded instead. This single-window write is new behaviour.
- Auto-return: while mapper_en=0 and cpu_addr[15]=1, all windows ← 0 every clock.
- Accept requires mapper_en=1 and auto-return requires mapper_en=0, so the two never coincide.
- Priority: reset > io_reset > write accept > auto-return > hold.

## Timing
- Reset (async assert): every page[w] = ROM_PAGE and old_wr = 1. ram_addr and rom_active follow combinationally: rom_active = 1 for addresses below FIXED_BASE; win_pages = ROM_PAGE replicated.
- Reset release is synchronous to clk_sys; the first write can be accepted on the second edge after release.
- io_reset: all windows become 0 on the first posedge at which it is high, and stay 0 while it is held.
- Write latency: the falling edge of cpu_wr_n is sampled at edge N (old_wr still 1). page[] updates at edge N. The new mapping appears on ram_addr immediately after edge N.
- cpu_wr_n held low for many clocks: no re-accept. A glitch-free high→low transition is required for each accept.
- page_sel or cpu_addr changing while cpu_wr_n is low after the accept edge: ignored.
- mapper_en dropping mid-write: no accept. Auto-return applies from that clock if cpu_addr[15]=1.
- ram_addr, rom_active and win_pages have no registered output stage: combinational from state plus cpu_addr.

## Test plan
- Reset, then read map: assert reset; check win_pages = 16'h1111, ram_addr for cpu_addr 0x1234 = 0x011234, rom_active = 1; for cpu_addr 0xFFC5, ram_addr = 0x00FFC5 and rom_active = 0.
- Global RAM-disk select: mapper_en=1; write 0x0D to 0xFFFD. One clock later win_pages = 16'h7777 (2+5), ram_addr(0x8000) = 0x078000. Hold cpu_wr_n low 10 clocks while changing cpu_dout; no further change.
- Per-window write: write 0x43 to 0xFFFF (window 1 ← page 5) starting from all-ROM. Expect win_pages = 16'h1151, ram_addr(0x4001) = 0x054001, rom_active(0x4001) = 0, rom_active(0x0001) = 1.
- Auto-return: pages = 16'h3333, mapper_en=0, cpu_addr 0x7FFF for 5 clocks → unchanged. cpu_addr 0x8000 for one clock → win_pages = 0. A write to 0xFFFE while mapper_en=0 is ignored.
- io_reset priority: assert io_reset in the same clock as an accepted write of 0xFFFE. Expect win_pages = 0. After release, write 0xFFFE → 16'h1111.
- Async reset mid-write: assert reset between cpu_wr_n falling and the next clk_sys edge. Expect immediate ROM_PAGE everywhere, and no accept after release until cpu_wr_n goes high then low again.
